blake_round_sequencer: RTL

BLAKE_ROUND_SEQUENCER -- requirements
Module: blake_round_sequencer

---
 rtl/blake_pkg.sv | 22 ++
 rtl/blake_wrap_counter.sv | 33 +++
 rtl/blake_round_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/blake_pkg.sv
// Shared types, default schedule constants and counter width helper for the
// BLAKE round sequencer.
package blake_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_t;

  localparam int DEF_NUM_ROUNDS      = 16;
  localparam int DEF_STEPS_PER_ROUND = 4;
  localparam int DEF_SIGMA_PERIOD    = 10;

  // Counter width for a modulus n; a modulus of 1 still gets one (constant-0) bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blake_wrap_counter.sv
// Modulo-MOD counter with synchronous clear (priority over enable) and a
// wrap flag decoded from the count register.
module blake_wrap_counter
  import blake_pkg::*;
#(
  parameter int MOD = 4,
  parameter int W   = cnt_w(MOD)
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         wrap
);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap  = (cnt_q == W'(MOD - 1));
  assign value = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/blake_round_sequencer.sv
// Control sequencer for a BLAKE compression: IDLE/INIT/ROUND/FINAL/DONE with
// step, round and sigma counters. Define BLAKE_SEQ_ABORT_EN to add abort/aborted.
module blake_round_sequencer
  import blake_pkg::*;
#(
  parameter int NUM_ROUNDS      = DEF_NUM_ROUNDS,
  parameter int STEPS_PER_ROUND = DEF_STEPS_PER_ROUND,
  parameter int SIGMA_PERIOD    = DEF_SIGMA_PERIOD,
  localparam int RW = cnt_w(NUM_ROUNDS),
  localparam int SW = cnt_w(STEPS_PER_ROUND)
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          ena,
  input  logic          last_block,
  output logic          ready,
  output logic          busy,
  output logic          init_round,
  output logic          round_ing,
  output logic          step_en,
  output logic [RW-1:0] round_idx,
  output logic [SW-1:0] step_idx,
  output logic [3:0]    sigma_idx,
  output logic          last_step,
  output logic          final_en,
  output logic          done,
  output logic          digest_valid
`ifdef BLAKE_SEQ_ABORT_EN
  ,
  input  logic          abort,
  output logic          aborted
`endif
);

  state_t state_q, state_d;
  logic   lb_q, lb_d;
  logic   abort_hit;
  logic   in_round, cnt_clr, step_wrap, round_wrap, sigma_wrap;

  assign in_round = (state_q == ST_ROUND);

`ifdef BLAKE_SEQ_ABORT_EN
  logic aborted_q, aborted_d;
  assign abort_hit = abort && (state_q inside {ST_INIT, ST_ROUND, ST_FINAL});
  assign aborted_d = abort_hit;
  assign aborted   = aborted_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) aborted_q <= 1'b0;
    else       aborted_q <= aborted_d;
  end
`else
  assign abort_hit = 1'b0;
`endif

  // Counters only run in ROUND; every other state (and an abort) holds them at zero.
  assign cnt_clr = !in_round || abort_hit;

  blake_wrap_counter #(.MOD(STEPS_PER_ROUND), .W(SW)) u_step (
    .clk(clk), .rstb(rstb), .en(in_round), .clr(cnt_clr),
    .value(step_idx), .wrap(step_wrap)
  );

  blake_wrap_counter #(.MOD(NUM_ROUNDS), .W(RW)) u_round (
    .clk(clk), .rstb(rstb), .en(in_round && step_wrap), .clr(cnt_clr),
    .value(round_idx), .wrap(round_wrap)
  );

  blake_wrap_counter #(.MOD(SIGMA_PERIOD), .W(4)) u_sigma (
    .clk(clk), .rstb(rstb), .en(in_round && step_wrap), .clr(cnt_clr),
    .value(sigma_idx), .wrap(sigma_wrap)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
      lb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lb_q    <= lb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lb_d    = lb_q;
    unique case (state_q)
      ST_IDLE: if (ena) begin
        state_d = ST_INIT;
        lb_d    = last_block;
      end
      ST_INIT:  state_d = ST_ROUND;
      ST_ROUND: if (step_wrap && round_wrap) state_d = ST_FINAL;
      ST_FINAL: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort_hit) state_d = ST_IDLE;
  end

  always_comb begin
    ready        = (state_q == ST_IDLE);
    busy         = !ready;
    init_round   = (state_q == ST_INIT);
    round_ing    = in_round;
    step_en      = in_round;
    last_step    = in_round && step_wrap && round_wrap;
    final_en     = (state_q == ST_FINAL);
    done         = (state_q == ST_DONE);
    digest_valid = (state_q == ST_DONE) && lb_q;
  end

  logic unused_ok;
  assign unused_ok = sigma_wrap;

endmodule
